// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC-3 microsequencer: state numbers, opcodes,
// datapath mux/ALU encodings and the per-state control word.
package lc3_ctrl_pkg;

    // State values are the LC-3 microarchitecture state numbers.
    typedef enum logic [5:0] {
        S_BR       = 6'd0,
        S_ADD      = 6'd1,
        S_LD       = 6'd2,
        S_ST       = 6'd3,
        S_AND      = 6'd5,
        S_NOT      = 6'd9,
        S_JMP      = 6'd12,
        S_LEA      = 6'd14,
        S_ST_WR    = 6'd16,
        S_FETCH0   = 6'd18,
        S_BR_TAKEN = 6'd22,
        S_ST_MDR   = 6'd23,
        S_LD_RD    = 6'd25,
        S_LD_WB    = 6'd27,
        S_DECODE   = 6'd32,
        S_FETCH_RD = 6'd33,
        S_FETCH_IR = 6'd35
    } state_e;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    localparam logic [1:0] SR1_IR11_9 = 2'b00;
    localparam logic [1:0] SR1_IR8_6  = 2'b01;

    localparam logic [1:0] DR_IR11_9  = 2'b00;
    localparam logic [1:0] DR_R7      = 2'b10;

    localparam logic [1:0] PC_INC     = 2'b00;
    localparam logic [1:0] PC_BUS     = 2'b01;
    localparam logic [1:0] PC_ADDER   = 2'b10;

    localparam logic       ADDR1_PC   = 1'b0;
    localparam logic       ADDR1_SR1  = 1'b1;
    localparam logic [1:0] ADDR2_ZERO = 2'b00;
    localparam logic [1:0] ADDR2_OFF9 = 2'b10;
    localparam logic       MARMUX_ADDER = 1'b1;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_reg;
        logic       ld_cc;
        logic       ld_pc;
        logic       gate_pc;
        logic       gate_marmux;
        logic       gate_alu;
        logic       gate_mdr;
        logic [1:0] aluk;
        logic [1:0] sr1mux;
        logic [1:0] drmux;
        logic [1:0] pcmux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic       marmux;
        logic       mio_en;
        logic       r_w;
    } ctrl_word_t;

    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH_RD) || (s == S_LD_RD) || (s == S_ST_WR);
    endfunction

endpackage

// File: rtl/lc3_control_unit_if.sv
// Control-unit <-> datapath signal bundle. The control unit is the master:
// it consumes IR, condition codes and memory ready and drives every control.
interface lc3_control_unit_if;
    logic [15:0] i_IR;
    logic        i_N;
    logic        i_Z;
    logic        i_P;
    logic        i_Mem_R;

    logic        o_LD_MAR, o_LD_MDR, o_LD_IR, o_LD_REG, o_LD_CC, o_LD_PC;
    logic        o_GatePC, o_GateMARMUX, o_GateALU, o_GateMDR;
    logic [1:0]  o_ALUK;
    logic [1:0]  o_SR1MUX;
    logic [1:0]  o_DRMUX;
    logic [1:0]  o_PCMUX;
    logic        o_ADDR1MUX;
    logic [1:0]  o_ADDR2MUX;
    logic        o_MARMUX;
    logic        o_MIO_EN;
    logic        o_R_W;
    logic [5:0]  o_State;
    logic        o_Timeout;

    modport master (
        input  i_IR, i_N, i_Z, i_P, i_Mem_R,
        output o_LD_MAR, o_LD_MDR, o_LD_IR, o_LD_REG, o_LD_CC, o_LD_PC,
        output o_GatePC, o_GateMARMUX, o_GateALU, o_GateMDR,
        output o_ALUK, o_SR1MUX, o_DRMUX, o_PCMUX, o_ADDR1MUX, o_ADDR2MUX,
        output o_MARMUX, o_MIO_EN, o_R_W, o_State, o_Timeout
    );

    modport slave (
        output i_IR, i_N, i_Z, i_P, i_Mem_R,
        input  o_LD_MAR, o_LD_MDR, o_LD_IR, o_LD_REG, o_LD_CC, o_LD_PC,
        input  o_GatePC, o_GateMARMUX, o_GateALU, o_GateMDR,
        input  o_ALUK, o_SR1MUX, o_DRMUX, o_PCMUX, o_ADDR1MUX, o_ADDR2MUX,
        input  o_MARMUX, o_MIO_EN, o_R_W, o_State, o_Timeout
    );
endinterface

// File: rtl/lc3_ctrl_decode.sv
// Pure state -> control-word decoder; anything a state does not name stays 0,
// which also keeps at most one bus gate active per state.
module lc3_ctrl_decode
    import lc3_ctrl_pkg::*;
(
    input  state_e     i_state,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        // NOTE: assigning a full default first means no path leaves a field unassigned, so no latch is inferred.
        o_ctrl = '0;
        case (i_state)
            S_FETCH0: begin
                o_ctrl.gate_pc = 1'b1;
                o_ctrl.ld_mar  = 1'b1;
                o_ctrl.ld_pc   = 1'b1;
                o_ctrl.pcmux   = PC_INC;
            end
            S_FETCH_RD, S_LD_RD: begin
                o_ctrl.mio_en = 1'b1;
                o_ctrl.ld_mdr = 1'b1;
            end
            S_FETCH_IR: begin
                o_ctrl.gate_mdr = 1'b1;
                o_ctrl.ld_ir    = 1'b1;
            end
            S_ADD, S_AND, S_NOT: begin
                o_ctrl.gate_alu = 1'b1;
                o_ctrl.aluk     = (i_state == S_AND) ? ALUK_AND :
                                  (i_state == S_NOT) ? ALUK_NOT : ALUK_ADD;
                o_ctrl.sr1mux   = SR1_IR8_6;
                o_ctrl.drmux    = DR_IR11_9;
                o_ctrl.ld_reg   = 1'b1;
                o_ctrl.ld_cc    = 1'b1;
            end
            S_LEA: begin
                o_ctrl.addr1mux    = ADDR1_PC;
                o_ctrl.addr2mux    = ADDR2_OFF9;
                o_ctrl.marmux      = MARMUX_ADDER;
                o_ctrl.gate_marmux = 1'b1;
                o_ctrl.drmux       = DR_IR11_9;
                o_ctrl.ld_reg      = 1'b1;
                o_ctrl.ld_cc       = 1'b1;
            end
            S_LD, S_ST: begin
                o_ctrl.addr1mux    = ADDR1_PC;
                o_ctrl.addr2mux    = ADDR2_OFF9;
                o_ctrl.marmux      = MARMUX_ADDER;
                o_ctrl.gate_marmux = 1'b1;
                o_ctrl.ld_mar      = 1'b1;
            end
            S_LD_WB: begin
                o_ctrl.gate_mdr = 1'b1;
                o_ctrl.drmux    = DR_IR11_9;
                o_ctrl.ld_reg   = 1'b1;
                o_ctrl.ld_cc    = 1'b1;
            end
            S_ST_MDR: begin
                o_ctrl.sr1mux   = SR1_IR11_9;
                o_ctrl.aluk     = ALUK_PASSA;
                o_ctrl.gate_alu = 1'b1;
                o_ctrl.ld_mdr   = 1'b1;
            end
            S_ST_WR: begin
                o_ctrl.mio_en = 1'b1;
                o_ctrl.r_w    = 1'b1;
            end
            S_BR_TAKEN: begin
                o_ctrl.addr1mux = ADDR1_PC;
                o_ctrl.addr2mux = ADDR2_OFF9;
                o_ctrl.pcmux    = PC_ADDER;
                o_ctrl.ld_pc    = 1'b1;
            end
            S_JMP: begin
                o_ctrl.sr1mux   = SR1_IR8_6;
                o_ctrl.addr1mux = ADDR1_SR1;
                o_ctrl.addr2mux = ADDR2_ZERO;
                o_ctrl.pcmux    = PC_ADDER;
                o_ctrl.ld_pc    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lc3_control_unit.sv
// LC-3 Moore microsequencer: state register, next-state/dispatch logic and
// the memory-wait watchdog. Outputs come only from the registered state.
module lc3_control_unit
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                i_CLK,
    input  logic                i_Reset,
    lc3_control_unit_if.master  bus
);

    localparam int          CNT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout;

    state_e           w_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_abort;
    logic             w_br_taken;
    ctrl_word_t       w_ctrl;

    assign w_br_taken = (bus.i_IR[11] & bus.i_N) | (bus.i_IR[10] & bus.i_Z) |
                        (bus.i_IR[9] & bus.i_P);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = '0;
        w_abort    = 1'b0;
        case (r_state)
            S_FETCH0:   w_next = S_FETCH_RD;
            S_FETCH_RD: if (bus.i_Mem_R) w_next = S_FETCH_IR;
            S_FETCH_IR: w_next = S_DECODE;
            S_DECODE: begin
                case (bus.i_IR[15:12])
                    OP_ADD:  w_next = S_ADD;
                    OP_AND:  w_next = S_AND;
                    OP_NOT:  w_next = S_NOT;
                    OP_LEA:  w_next = S_LEA;
                    OP_LD:   w_next = S_LD;
                    OP_ST:   w_next = S_ST;
                    OP_BR:   w_next = S_BR;
                    OP_JMP:  w_next = S_JMP;
                    default: w_next = S_FETCH0;
                endcase
            end
            S_LD:       w_next = S_LD_RD;
            S_LD_RD:    if (bus.i_Mem_R) w_next = S_LD_WB;
            S_ST:       w_next = S_ST_MDR;
            S_ST_MDR:   w_next = S_ST_WR;
            S_ST_WR:    if (bus.i_Mem_R) w_next = S_FETCH0;
            S_BR:       w_next = w_br_taken ? S_BR_TAKEN : S_FETCH0;
            default:    w_next = S_FETCH0;
        endcase

        // The counter holds the waits already spent; the abort fires on the
        // MEM_TIMEOUT-th stalled cycle.
        if (is_mem_state(r_state) && !bus.i_Mem_R) begin
            if (TIMEOUT_EN && (r_wait_cnt == CNT_LAST)) begin
                w_abort = 1'b1;
                w_next  = S_FETCH0;
            end else begin
                w_cnt_next = r_wait_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        // NOTE: non-blocking assignments make every register here sample pre-edge values, independent of statement order.
        if (i_Reset) begin
            r_state    <= S_FETCH0;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_cnt_next;
            r_timeout  <= w_abort;
        end
    end

    lc3_ctrl_decode u_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    assign bus.o_LD_MAR     = w_ctrl.ld_mar;
    assign bus.o_LD_MDR     = w_ctrl.ld_mdr;
    assign bus.o_LD_IR      = w_ctrl.ld_ir;
    assign bus.o_LD_REG     = w_ctrl.ld_reg;
    assign bus.o_LD_CC      = w_ctrl.ld_cc;
    assign bus.o_LD_PC      = w_ctrl.ld_pc;
    assign bus.o_GatePC     = w_ctrl.gate_pc;
    assign bus.o_GateMARMUX = w_ctrl.gate_marmux;
    assign bus.o_GateALU    = w_ctrl.gate_alu;
    assign bus.o_GateMDR    = w_ctrl.gate_mdr;
    assign bus.o_ALUK       = w_ctrl.aluk;
    assign bus.o_SR1MUX     = w_ctrl.sr1mux;
    assign bus.o_DRMUX      = w_ctrl.drmux;
    assign bus.o_PCMUX      = w_ctrl.pcmux;
    assign bus.o_ADDR1MUX   = w_ctrl.addr1mux;
    assign bus.o_ADDR2MUX   = w_ctrl.addr2mux;
    assign bus.o_MARMUX     = w_ctrl.marmux;
    assign bus.o_MIO_EN     = w_ctrl.mio_en;
    assign bus.o_R_W        = w_ctrl.r_w;
    assign bus.o_State      = r_state;
    assign bus.o_Timeout    = r_timeout;

endmodule
